// File: rtl/hash_pkg.sv
// Shared SHA constants, state encoding and bit-mixing helpers.
// Used by the message-schedule stream and by the round cores.
package hash_pkg;

    localparam logic MODE_SHA1   = 1'b0;
    localparam logic MODE_SHA256 = 1'b1;

    localparam int R_SHA1_DFLT   = 80;
    localparam int R_SHA256_DFLT = 64;

    typedef enum logic {
        WS_IDLE = 1'b0,
        WS_RUN  = 1'b1
    } wsched_state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha_w_next.sv
// Combinational next-word unit for the 16-word schedule window.
// Taps are window positions; position 0 is the word leaving the window.
module sha_w_next
    import hash_pkg::*;
(
    input  logic        mode,
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [31:0] w2,
    input  logic [31:0] w8,
    input  logic [31:0] w9,
    input  logic [31:0] w13,
    input  logic [31:0] w14,
    output logic [31:0] nxt
);

    always_comb begin
        if (mode == MODE_SHA256) begin
            nxt = s1(w14) + w9 + s0(w1) + w0;
        end else begin
            nxt = rotl(w13 ^ w8 ^ w2 ^ w0, 1);
        end
    end

endmodule

// File: rtl/sha_wsched_stream.sv
// SHA-1 / SHA-256 message-schedule generator: loads a 512-bit block and
// streams W_0..W_{R-1} over a valid/ready interface with full backpressure.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no block held; in_ready=1 unless flush
//   RUN   | win[0] offered as W_cnt; last beat may reload (zero bubble)
module sha_wsched_stream
    import hash_pkg::*;
#(
    parameter int N         = 32,
    parameter int BLK_W     = 512,
    parameter int R_SHA1    = R_SHA1_DFLT,
    parameter int R_SHA256  = R_SHA256_DFLT,
    parameter int BYTE_SWAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [BLK_W-1:0] in_block,
    input  logic             flush,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [N-1:0]     w_data,
    output logic [6:0]       w_round,
    output logic             w_last,
    output logic             busy
);

    if (N != 32) begin : g_bad_n
        $error("sha_wsched_stream: N must be 32");
    end
    if (BLK_W != 16 * N) begin : g_bad_blk
        $error("sha_wsched_stream: BLK_W must be 16*N");
    end
    if (R_SHA1 < 16 || R_SHA1 > 128 || R_SHA256 < 16 || R_SHA256 > 128) begin : g_bad_r
        $error("sha_wsched_stream: round counts must lie in 16..128");
    end

    localparam logic [6:0] LAST_SHA1   = 7'(R_SHA1 - 1);
    localparam logic [6:0] LAST_SHA256 = 7'(R_SHA256 - 1);

    wsched_state_t state;
    logic          mode_q;
    logic [6:0]    cnt;
    logic [N-1:0]  win       [16];
    logic [N-1:0]  load_word [16];
    logic [N-1:0]  nxt;
    logic [6:0]    r_last;
    logic          beat;
    logic          accept;

    for (genvar i = 0; i < 16; i++) begin : g_load
        logic [N-1:0] raw;
        assign raw          = in_block[BLK_W-1-i*N -: N];
        assign load_word[i] = (BYTE_SWAP != 0) ? bswap32(raw) : raw;
    end

    sha_w_next u_next (
        .mode (mode_q),
        .w0   (win[0]),
        .w1   (win[1]),
        .w2   (win[2]),
        .w8   (win[8]),
        .w9   (win[9]),
        .w13  (win[13]),
        .w14  (win[14]),
        .nxt  (nxt)
    );

    assign r_last  = (mode_q == MODE_SHA256) ? LAST_SHA256 : LAST_SHA1;
    assign w_valid = (state == WS_RUN);
    assign busy    = (state == WS_RUN);
    assign w_data  = win[0];
    assign w_round = cnt;
    assign w_last  = w_valid && (cnt == r_last);
    assign beat    = w_valid && w_ready;

    // Combinational reload on the last beat gives back-to-back blocks with no gap.
    assign in_ready = !flush && ((state == WS_IDLE) || (beat && w_last));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WS_IDLE;
            mode_q <= MODE_SHA1;
            cnt    <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (flush) begin
            state <= WS_IDLE;
            cnt   <= '0;
        end else begin
            if (beat) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= nxt;
                cnt     <= cnt + 7'd1;
                if (w_last) begin
                    state <= WS_IDLE;
                    cnt   <= '0;
                end
            end
            if (accept) begin
                for (int i = 0; i < 16; i++) begin
                    win[i] <= load_word[i];
                end
                cnt    <= '0;
                mode_q <= in_mode;
                state  <= WS_RUN;
            end
        end
    end

endmodule

// File: tb/tb_sha_wsched_stream.sv
// Self-checking bench for sha_wsched_stream: hand vectors, textbook W model,
// random backpressure, back-to-back, flush, mid-block reset and byte swap.
module tb_sha_wsched_stream;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_mode, flush, w_ready;
    logic [511:0] in_block;
    logic         in_ready, w_valid, w_last, busy;
    logic [31:0]  w_data;
    logic [6:0]   w_round;

    logic         bs_in_valid, bs_flush, bs_w_ready;
    logic         bs_in_ready, bs_w_valid, bs_w_last, bs_busy;
    logic [511:0] bs_in_block;
    logic [31:0]  bs_w_data;
    logic [6:0]   bs_w_round;

    sha_wsched_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_block(in_block), .flush(flush),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_round(w_round), .w_last(w_last), .busy(busy)
    );

    sha_wsched_stream #(.BYTE_SWAP(1)) dut_bs (
        .clk(clk), .rst(rst), .in_valid(bs_in_valid), .in_ready(bs_in_ready),
        .in_mode(1'b0), .in_block(bs_in_block), .flush(bs_flush),
        .w_valid(bs_w_valid), .w_ready(bs_w_ready), .w_data(bs_w_data),
        .w_round(bs_w_round), .w_last(bs_w_last), .busy(bs_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [80];
    logic [31:0] got_d [$];
    int          got_r [$];
    int          got_last_t;
    int          stall_err;
    logic [31:0] s1_got   [80];
    logic [31:0] s256_got [64];

    typedef struct {
        logic        mode;
        int          t;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model(input logic m, input logic [511:0] blk);
        for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            if (m) begin
                exp_w[t] = (m_rotr(exp_w[t-2], 17) ^ m_rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (m_rotr(exp_w[t-15], 7) ^ m_rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end else begin
                logic [31:0] x;
                x = exp_w[t-3] ^ exp_w[t-8] ^ exp_w[t-14] ^ exp_w[t-16];
                exp_w[t] = {x[30:0], x[31]};
            end
        end
    endtask

    task automatic send_block(input logic m, input logic [511:0] blk, input bit keep_valid);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_block = blk;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            ok = in_ready;
            tick();
        end
        if (!keep_valid) in_valid = 1'b0;
        checkint("block_accept", int'(ok), 1);
    endtask

    task automatic collect(input int pct);
        bit          done, have_prev;
        logic [31:0] prev_d;
        logic [6:0]  prev_r;
        got_d.delete();
        got_r.delete();
        got_last_t = -1;
        stall_err  = 0;
        done       = 0;
        have_prev  = 0;
        prev_d     = '0;
        prev_r     = '0;
        for (int c = 0; c < 3000 && !done; c++) begin
            w_ready = ($urandom_range(99) < pct);
            #1;
            if (have_prev && (!w_valid || w_data !== prev_d || w_round !== prev_r)) stall_err++;
            have_prev = 0;
            if (w_valid) begin
                if (w_ready) begin
                    got_d.push_back(w_data);
                    got_r.push_back(int'(w_round));
                    if (w_last) begin
                        got_last_t = int'(w_round);
                        done = 1;
                    end
                end else begin
                    have_prev = 1;
                    prev_d    = w_data;
                    prev_r    = w_round;
                end
            end
            tick();
        end
        w_ready = 1'b0;
        checkint("stream_terminated", int'(done), 1);
    endtask

    task automatic verify_stream(input string name, input logic m, input logic [511:0] blk);
        int r, n;
        build_model(m, blk);
        r = m ? 64 : 80;
        n = (got_d.size() < r) ? got_d.size() : r;
        checkint({name, "_len"}, got_d.size(), r);
        checkint({name, "_last_t"}, got_last_t, r - 1);
        checkint({name, "_stall_stable"}, stall_err, 0);
        for (int i = 0; i < n; i++) begin
            check32($sformatf("%s_w%0d", name, i), got_d[i], exp_w[i]);
            checkint($sformatf("%s_round%0d", name, i), got_r[i], i);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checkint({name, "_in_ready"}, int'(in_ready), 1);
        checkint({name, "_w_valid"}, int'(w_valid), 0);
        checkint({name, "_w_last"}, int'(w_last), 0);
        checkint({name, "_w_round"}, int'(w_round), 0);
        check32({name, "_w_data"}, w_data, 32'h0);
        checkint({name, "_busy"}, int'(busy), 0);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc, blk_b, blk_c;
        bit           found;
        int           early;

        abc = {32'h61626380, 448'h0, 32'h00000018};

        vecs[0] = '{1'b0, 0,  32'h61626380};
        vecs[1] = '{1'b0, 15, 32'h00000018};
        vecs[2] = '{1'b0, 16, 32'hC2C4C700};
        vecs[3] = '{1'b1, 0,  32'h61626380};
        vecs[4] = '{1'b1, 15, 32'h00000018};
        vecs[5] = '{1'b1, 16, 32'h61626380};
        vecs[6] = '{1'b1, 17, 32'h000F0000};

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_block = '0;
        flush = 1'b0; w_ready = 1'b0;
        bs_in_valid = 1'b0; bs_flush = 1'b0; bs_w_ready = 1'b0; bs_in_block = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        flush = 1'b1;
        #1;
        checkint("idle_flush_in_ready", int'(in_ready), 0);
        flush = 1'b0;
        tick();

        // SHA-1 and SHA-256 "abc" with w_ready held high
        send_block(1'b0, abc, 0);
        collect(100);
        verify_stream("sha1_abc", 1'b0, abc);
        for (int i = 0; i < 80; i++) s1_got[i] = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;

        send_block(1'b1, abc, 0);
        collect(100);
        verify_stream("sha256_abc", 1'b1, abc);
        for (int i = 0; i < 64; i++) s256_got[i] = (i < got_d.size()) ? got_d[i] : 32'hxxxxxxxx;

        for (int v = 0; v < 7; v++) begin
            check32($sformatf("vec%0d_mode%0d_t%0d", v, vecs[v].mode, vecs[v].t),
                    vecs[v].mode ? s256_got[vecs[v].t] : s1_got[vecs[v].t], vecs[v].exp);
        end

        // Random backpressure
        blk_b = rand_block();
        send_block(1'b1, blk_b, 0);
        collect(50);
        verify_stream("rand256", 1'b1, blk_b);
        blk_b = rand_block();
        send_block(1'b0, blk_b, 0);
        collect(50);
        verify_stream("rand1", 1'b0, blk_b);

        // Back-to-back: second block accepted on the last beat of the first
        blk_b = rand_block();
        send_block(1'b0, abc, 1);
        in_mode  = 1'b1;
        in_block = blk_b;
        w_ready  = 1'b1;
        found = 0;
        early = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            #1;
            if (w_valid && w_last) begin
                found = 1;
                checkint("b2b_ready_on_last", int'(in_ready), 1);
            end else if (in_ready) begin
                early++;
            end
            tick();
        end
        in_valid = 1'b0;
        checkint("b2b_last_seen", int'(found), 1);
        checkint("b2b_no_early_ready", early, 0);
        #1;
        checkint("b2b_no_gap_valid", int'(w_valid), 1);
        checkint("b2b_t0_round", int'(w_round), 0);
        check32("b2b_t0_data", w_data, blk_b[511:480]);
        collect(100);
        verify_stream("b2b_blk2", 1'b1, blk_b);

        // Flush at t=20, then a new block
        blk_c = rand_block();
        send_block(1'b1, blk_c, 0);
        w_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            #1;
            if (w_valid && w_round == 7'd20) found = 1;
            else tick();
        end
        checkint("flush_reached_t20", int'(found), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_block = abc;
        #1;
        checkint("flush_blocks_in_ready", int'(in_ready), 0);
        tick();
        flush = 1'b0;
        #1;
        checkint("flush_w_valid", int'(w_valid), 0);
        checkint("flush_busy", int'(busy), 0);
        checkint("flush_cnt_cleared", int'(w_round), 0);
        send_block(1'b0, abc, 0);
        collect(100);
        verify_stream("after_flush", 1'b0, abc);

        // Reset at t=5, then a new block
        send_block(1'b0, blk_c, 0);
        w_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            #1;
            if (w_valid && w_round == 7'd5) found = 1;
            else tick();
        end
        checkint("rst_reached_t5", int'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_ready = 1'b0;
        #1;
        check_reset_outputs("midblock_rst");
        send_block(1'b1, abc, 0);
        collect(100);
        verify_stream("after_rst", 1'b1, abc);

        // Byte-swapped source
        bs_in_block = {32'h80636261, 448'h0, 32'h18000000};
        bs_in_valid = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            #1;
            found = bs_in_ready;
            tick();
        end
        bs_in_valid = 1'b0;
        checkint("bs_accept", int'(found), 1);
        #1;
        checkint("bs_w_valid", int'(bs_w_valid), 1);
        checkint("bs_t0_round", int'(bs_w_round), 0);
        check32("bs_t0_data", bs_w_data, 32'h61626380);
        bs_w_ready = 1'b1;
        repeat (15) tick();
        bs_w_ready = 1'b0;
        #1;
        checkint("bs_t15_round", int'(bs_w_round), 15);
        check32("bs_t15_data", bs_w_data, 32'h00000018);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
